// File: rtl/complex_square_nch_pkg.sv
// Shared definitions for the N-channel complex squarer: mode and FSM encodings, output width helper.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package complex_square_nch_pkg;

    localparam logic MODE_SQUARE = 1'b0;   // z^2
    localparam logic MODE_MAGSQ  = 1'b1;   // |z|^2

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Output component width: the doubled worst-case product 2*(-2^(W-1))^2 = 2^(2W-1) needs 2W+1 signed bits.
    function automatic int owOf(input int width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/complex_square_nch_if.sv
// Frame-level bus of the complex squarer: input frame handshake, result frame handshake, busy flag.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the result side.
// Ports: master = frame producer/result consumer, slave = the squarer.
interface complex_square_nch_if
    import complex_square_nch_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int OW = owOf(WIDTH);

    logic                       in_valid;
    logic                       in_ready;
    logic                       mode;
    logic [CHANNELS*WIDTH-1:0]  in_real;
    logic [CHANNELS*WIDTH-1:0]  in_imag;
    logic                       out_valid;
    logic                       out_ready;
    logic [CHANNELS*OW-1:0]     out_real;
    logic [CHANNELS*OW-1:0]     out_imag;
    logic                       busy;

    modport master (
        output in_valid, mode, in_real, in_imag, out_ready,
        input  in_ready, out_valid, out_real, out_imag, busy
    );

    modport slave (
        input  in_valid, mode, in_real, in_imag, out_ready,
        output in_ready, out_valid, out_real, out_imag, busy
    );

endinterface

// File: rtl/complex_square_nch_core.sv
// Single-channel complex squarer: stage 1 registers a*a, b*b, a*b; stage 2 combines them combinationally.
// Latency: result valid one cycle after issue (the consumer's register is the second stage).
// Backpressure: none; the issuer paces the core one channel per cycle.
// Ports: clk/rst, a/b signed sample, mode, issueVld in; resReal/resImag/resVld out.
module complex_sq_core
    import complex_square_nch_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int OW    = owOf(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    mode,
    input  logic                    issueVld,
    output logic signed [OW-1:0]    resReal,
    output logic signed [OW-1:0]    resImag,
    output logic                    resVld
);
    localparam int PW = 2 * WIDTH;

    logic signed [PW-1:0] aW, bW;
    logic signed [PW-1:0] aaQ, bbQ, abQ;
    logic                 modeQ, vldQ;
    logic signed [OW-1:0] aaX, bbX, abX;

    // Widen before multiplying so the product is formed at full precision.
    assign aW = PW'(a);
    assign bW = PW'(b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aaQ   <= '0;
            bbQ   <= '0;
            abQ   <= '0;
            modeQ <= MODE_SQUARE;
            vldQ  <= 1'b0;
        end else begin
            vldQ <= issueVld;
            if (issueVld) begin
                aaQ   <= aW * aW;
                bbQ   <= bW * bW;
                abQ   <= aW * bW;
                modeQ <= mode;
            end
        end
    end

    always_comb begin
        aaX     = OW'(aaQ);
        bbX     = OW'(bbQ);
        abX     = OW'(abQ);
        resVld  = vldQ;
        if (modeQ == MODE_MAGSQ) begin
            resReal = aaX + bbX;
            resImag = '0;
        end else begin
            resReal = aaX - bbX;
            resImag = abX <<< 1;
        end
    end

endmodule

// File: rtl/complex_square_nch.sv
// N-channel complex squarer: latches a frame, runs channels through one shared core, presents all results.
// Latency: out_valid CHANNELS+1 cycles after accept; frame period CHANNELS+3 cycles.
// Backpressure: in_ready only in IDLE; results held until out_ready, IDLE resumes the cycle after.
// Ports: clk, rst (async active-low), bus (slave side of complex_square_nch_if).
module complex_square_nch
    import complex_square_nch_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    complex_square_nch_if.slave  bus
);
    localparam int            OW   = owOf(WIDTH);
    localparam int            IW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);

    state_t                    state, nextState;
    logic [IW-1:0]             idx, wrIdx;
    logic [CHANNELS*WIDTH-1:0] latReal, latImag;
    logic                      latMode;
    logic [CHANNELS*OW-1:0]    outRealQ, outImagQ;
    logic                      accept, issueVld;
    logic signed [WIDTH-1:0]   chA, chB;
    logic signed [OW-1:0]      coreReal, coreImag;
    logic                      coreVld;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.in_valid)  nextState = COMPUTE;
            COMPUTE: if (idx == LAST)   nextState = DRAIN;
            DRAIN:                      nextState = DONE;
            DONE:    if (bus.out_ready) nextState = IDLE;
            default:                    nextState = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.busy      = (state != IDLE);
        bus.out_valid = (state == DONE);
        issueVld      = (state == COMPUTE);
    end

    assign accept = bus.in_valid && (state == IDLE);

    // Input latch, issue counter and result write pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            latReal  <= '0;
            latImag  <= '0;
            latMode  <= MODE_SQUARE;
            idx      <= '0;
            wrIdx    <= '0;
            outRealQ <= '0;
            outImagQ <= '0;
        end else begin
            if (accept) begin
                latReal <= bus.in_real;
                latImag <= bus.in_imag;
                latMode <= bus.mode;
                idx     <= '0;
                wrIdx   <= '0;
            end else if (issueVld && idx != LAST) begin
                idx <= idx + 1'b1;
            end
            // Results come back in issue order, so a plain counter tracks the destination slot.
            if (coreVld) begin
                outRealQ[int'(wrIdx)*OW +: OW] <= coreReal;
                outImagQ[int'(wrIdx)*OW +: OW] <= coreImag;
                if (wrIdx != LAST) wrIdx <= wrIdx + 1'b1;
            end
        end
    end

    assign chA = latReal[int'(idx)*WIDTH +: WIDTH];
    assign chB = latImag[int'(idx)*WIDTH +: WIDTH];

    complex_sq_core #(.WIDTH(WIDTH)) core (
        .clk      (clk),
        .rst      (rst),
        .a        (chA),
        .b        (chB),
        .mode     (latMode),
        .issueVld (issueVld),
        .resReal  (coreReal),
        .resImag  (coreImag),
        .resVld   (coreVld)
    );

    assign bus.out_real = outRealQ;
    assign bus.out_imag = outImagQ;

endmodule

// File: tb/tb_complex_square_nch.sv
// Bench for complex_square_nch: directed frames, random frames, backpressure, mid-frame reset, throughput.
// Latency: checks CHANNELS+1 cycles accept-to-valid and a CHANNELS+3 cycle frame period.
// Backpressure: holds out_ready low with a pending frame to check stability and input stall.
module tb_complex_square_nch;
    import complex_square_nch_pkg::*;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int OW = 2 * W + 1;
    localparam int FW = CH * W;
    localparam int RW = CH * OW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    complex_square_nch_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

    complex_square_nch #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nChecks = 0;
    int nPass   = 0;

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: plain integer complex arithmetic per channel.
    function automatic logic [RW-1:0] modelReal(input logic [FW-1:0] re, input logic [FW-1:0] im, input logic m);
        logic [RW-1:0] r;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            int a, b, v;
            logic [31:0] vb;
            a = $signed(re[k*W +: W]);
            b = $signed(im[k*W +: W]);
            v = m ? (a*a + b*b) : (a*a - b*b);
            vb = 32'(v);
            r[k*OW +: OW] = vb[OW-1:0];
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] modelImag(input logic [FW-1:0] re, input logic [FW-1:0] im, input logic m);
        logic [RW-1:0] r;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            int a, b, v;
            logic [31:0] vb;
            a = $signed(re[k*W +: W]);
            b = $signed(im[k*W +: W]);
            v = m ? 0 : 2*a*b;
            vb = 32'(v);
            r[k*OW +: OW] = vb[OW-1:0];
        end
        return r;
    endfunction

    function automatic logic [FW-1:0] packIn(input int v[CH]);
        logic [FW-1:0] p;
        p = '0;
        for (int k = 0; k < CH; k++) begin
            logic [31:0] t;
            t = 32'(v[k]);
            p[k*W +: W] = t[W-1:0];
        end
        return p;
    endfunction

    function automatic logic [RW-1:0] packOut(input int v[CH]);
        logic [RW-1:0] p;
        p = '0;
        for (int k = 0; k < CH; k++) begin
            logic [31:0] t;
            t = 32'(v[k]);
            p[k*OW +: OW] = t[OW-1:0];
        end
        return p;
    endfunction

    function automatic logic [FW-1:0] randFrame();
        logic [FW-1:0] p;
        for (int k = 0; k < CH; k++) p[k*W +: W] = W'($urandom);
        return p;
    endfunction

    task automatic driveFrame(input logic [FW-1:0] re, input logic [FW-1:0] im, input logic m);
        bus.in_real  = re;
        bus.in_imag  = im;
        bus.mode     = m;
        bus.in_valid = 1'b1;
    endtask

    // Called while the DUT is idle; returns #1 after the accepting edge.
    task automatic acceptFrame(input string tag);
        checkVal({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkVal({tag, "_busy"}, bus.busy, 1);
    endtask

    task automatic waitResult(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkVal({tag, "_latency"}, n, CH + 1);
    endtask

    task automatic checkResult(input string tag, input logic [FW-1:0] re, input logic [FW-1:0] im, input logic m);
        checkVal({tag, "_real"}, bus.out_real, modelReal(re, im, m));
        checkVal({tag, "_imag"}, bus.out_imag, modelImag(re, im, m));
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkVal({tag, "_valid_clr"}, bus.out_valid, 0);
        checkVal({tag, "_rdy_back"}, bus.in_ready, 1);
    endtask

    initial begin
        logic [FW-1:0] re, im, re2, im2;
        logic          m;
        int            ra[CH], ia[CH], er[CH], ei[CH];
        logic [FW-1:0] tRe[3], tIm[3];
        logic          tM[3];
        int            accT[$];
        int            resN, sent;
        logic          acc;

        // Reset held with random activity on the inputs
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.mode      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_real = randFrame();
            bus.in_imag = randFrame();
            bus.mode    = 1'($urandom);
            @(posedge clk); #1;
        end
        checkVal("rst_out_real", bus.out_real, 0);
        checkVal("rst_out_imag", bus.out_imag, 0);
        checkVal("rst_out_valid", bus.out_valid, 0);
        checkVal("rst_busy", bus.busy, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checkVal("rst_in_ready", bus.in_ready, 1);

        // Directed square frame with hand-computed results
        ra = '{3, -128, 127, 0};
        ia = '{4, -128, 0, -5};
        re = packIn(ra);
        im = packIn(ia);
        driveFrame(re, im, MODE_SQUARE);
        acceptFrame("sq");
        waitResult("sq");
        er = '{-7, 0, 16129, -25};
        ei = '{24, 32768, 0, 0};
        checkVal("sq_real_const", bus.out_real, packOut(er));
        checkVal("sq_imag_const", bus.out_imag, packOut(ei));
        checkResult("sq_model", re, im, MODE_SQUARE);
        handshake("sq");

        // Same inputs, magnitude squared
        driveFrame(re, im, MODE_MAGSQ);
        acceptFrame("mag");
        waitResult("mag");
        er = '{25, 32768, 16129, 25};
        ei = '{0, 0, 0, 0};
        checkVal("mag_real_const", bus.out_real, packOut(er));
        checkVal("mag_imag_const", bus.out_imag, packOut(ei));
        handshake("mag");

        // Random frames, random mode
        for (int f = 0; f < 8; f++) begin
            re = randFrame();
            im = randFrame();
            m  = 1'($urandom);
            driveFrame(re, im, m);
            acceptFrame("rnd");
            waitResult("rnd");
            checkResult("rnd", re, im, m);
            handshake("rnd");
        end

        // Backpressure: a new frame waits while the result is held
        re = randFrame();
        im = randFrame();
        driveFrame(re, im, MODE_SQUARE);
        acceptFrame("bp");
        waitResult("bp");
        re2 = randFrame();
        im2 = randFrame();
        driveFrame(re2, im2, MODE_MAGSQ);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkResult("bp_hold", re, im, MODE_SQUARE);
            checkVal("bp_in_ready", bus.in_ready, 0);
            checkVal("bp_out_valid", bus.out_valid, 1);
        end
        handshake("bp");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkVal("bp_new_accept", bus.busy, 1);
        waitResult("bp2");
        checkResult("bp2", re2, im2, MODE_MAGSQ);
        handshake("bp2");

        // Reset in the second compute cycle
        driveFrame(randFrame(), randFrame(), MODE_SQUARE);
        acceptFrame("mid");
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkVal("mid_out_real", bus.out_real, 0);
        checkVal("mid_out_imag", bus.out_imag, 0);
        checkVal("mid_out_valid", bus.out_valid, 0);
        checkVal("mid_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        ra = '{1, 1, 1, 1};
        driveFrame(packIn(ra), packIn(ra), MODE_SQUARE);
        acceptFrame("post");
        waitResult("post");
        er = '{0, 0, 0, 0};
        ei = '{2, 2, 2, 2};
        checkVal("post_real", bus.out_real, packOut(er));
        checkVal("post_imag", bus.out_imag, packOut(ei));
        handshake("post");

        // Throughput: in_valid and out_ready held high, mode toggling per frame
        tM = '{MODE_SQUARE, MODE_MAGSQ, MODE_SQUARE};
        for (int i = 0; i < 3; i++) begin
            tRe[i] = randFrame();
            tIm[i] = randFrame();
        end
        resN = 0;
        sent = 0;
        driveFrame(tRe[0], tIm[0], tM[0]);
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && resN < 3; cyc++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                checkResult("thr", tRe[resN], tIm[resN], tM[resN]);
                resN++;
            end
            @(posedge clk); #1;
            if (acc) begin
                accT.push_back(cyc);
                sent++;
                if (sent < 3) driveFrame(tRe[sent], tIm[sent], tM[sent]);
                else bus.in_valid = 1'b0;
            end
        end
        bus.out_ready = 1'b0;
        checkVal("thr_results", resN, 3);
        checkVal("thr_accepts", accT.size(), 3);
        if (accT.size() == 3) begin
            checkVal("thr_gap1", accT[1] - accT[0], CH + 3);
            checkVal("thr_gap2", accT[2] - accT[1], CH + 3);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/complex_square_nch.md
Name: complex_square_nch

Overview:
- Parametrised N-channel complex squarer for the sorter's metric front-end.
- Captures one frame of CHANNELS complex samples through a valid/ready handshake.
- Computes either z² or |z|² per channel on a single time-multiplexed, 2-stage pipelined datapath.
- Presents all results together under a valid/ready output handshake.

Parameters:
- WIDTH, 8, bit width of each signed two's-complement real/imag input component.
- CHANNELS, 4, complex samples per frame (≥1).
- OW, 2*WIDTH+1, output component width (derived; must not be overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  frame present on in_real/in_imag/mode.
- in_ready  output  1  block can accept a frame.
- mode  input  1  0 = square (z²), 1 = magnitude squared (|z|²); sampled at accept.
- in_real  input  CHANNELS*WIDTH  packed real parts, channel k at bits [k*WIDTH +: WIDTH].
- in_imag  input  CHANNELS*WIDTH  packed imaginary parts, same packing.
- out_valid  output  1  full result frame valid.
- out_ready  input  1  consumer accepts the result frame.
- out_real  output  CHANNELS*OW  packed signed real results, channel k at [k*OW +: OW].
- out_imag  output  CHANNELS*OW  packed signed imaginary results.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=0, async): state IDLE, channel index 0, pipeline registers 0, out_real/out_imag 0, out_valid 0, busy 0, in_ready 1 once reset releases.
- States:
  - IDLE: in_ready=1. Accept on in_valid&in_ready at edge E0: latch all inputs and mode, idx←0, go to COMPUTE.
  - COMPUTE: each edge issues channel idx to stage 1 (registered products a·a, b·b, a·b), idx increments. After issuing idx=CHANNELS-1, go to DRAIN.
  - DRAIN: stage 2 writes the last result. out_valid←1. Go to DONE.
  - DONE: out_valid=1. Outputs held stable until out_ready=1. The handshake edge clears out_valid and returns to IDLE.
- Stage 2 arithmetic:
  - mode 0: real = a²−b², imag = 2ab.
  - mode 1: real = a²+b², imag = 0.
  - All terms sign-extended to OW before add/sub, so no overflow or saturation. Worst case (−2^(W−1))² doubled = 2^(2W−1) fits in OW.
- Result for channel k is written at edge E0+k+2.
- out_valid rises at edge E0+CHANNELS+1. Latency is CHANNELS+1 cycles from accept.
- in_ready=0 outside IDLE. in_valid is ignored there, and latched data and mode do not change.
- out_ready while out_valid=0 has no effect.
- Output handshake and new acceptance cannot share an edge. in_ready rises the cycle after the output handshake. Back-to-back frame period is CHANNELS+3 cycles.
- out_real/out_imag may change during COMPUTE/DRAIN. They are only meaningful when out_valid=1, and hold the last frame while IDLE.
- Reset asserted mid-operation abandons the frame immediately. All outputs return to their reset values, and the next frame after release is unaffected.
- CHANNELS=1: idx counter width max(1,$clog2(CHANNELS)). COMPUTE lasts one cycle.

Decomposition:
- Shared package/header complex_defs:
  - Mode encodings MODE_SQUARE=0, MODE_MAGSQ=1.
  - State encodings IDLE/COMPUTE/DRAIN/DONE.
  - Output-width function OW(WIDTH).
- One sub-module, complex_sq_core: 2-stage pipelined single-channel datapath.
  - Inputs: a, b, mode, issue-valid.
  - Outputs: real, imag, result-valid.
- Top level holds the FSM, channel counter, input latch and output register array.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0, busy 0. After release, in_ready=1.
- Square, CHANNELS=4, WIDTH=8, channels (3,4),(−128,−128),(127,0),(0,−5) -> results (−7,24),(0,32768),(16129,0),(−25,0). out_valid exactly 5 cycles after accept.
- Magnitude, same inputs with mode=1 -> real 25, 32768, 16129, 25; every imag 0.
- Backpressure: out_ready=0 for 10 cycles after out_valid while in_valid=1 with new data -> outputs stable, in_ready 0. Then out_ready=1 for one cycle -> IDLE next cycle; the new frame is accepted only after that.
- Reset mid-COMPUTE: assert rst at the 2nd compute cycle -> outputs 0 immediately. After release, frame (1,1)×4 in square mode -> (0,2) on all channels.
- Throughput: in_valid and out_ready held high, 3 distinct frames -> accepts spaced exactly 7 cycles. Each result frame is correct, and mode is latched per frame when mode toggles between frames.
